// File: rtl/uart_apb_bridge.sv
// uart_apb_bridge: byte-stream command frames in, single 32-bit APB transfers out,
// response bytes back on the tx stream. Host debug/bring-up path for APB peripherals.
//
// Ports:
//   clk, rst_n_sync               clock, async active-low reset (pre-synchronised)
//   rx_data/rx_valid/rx_ready     command byte stream in
//   tx_data/tx_valid/tx_ready     response byte stream out
//   apbm_*                        APB initiator port (16-bit addr, 32-bit data)
//   busy                          high whenever a frame is in progress
//
// Frame: cmd (00 rd / 01 wr), addr LE x2, [wdata LE x4].
// Reply: rd -> prdata LE x4 + status, wr -> status. Status 00 ok, 01 slverr, 02 bad cmd.
module uart_apb_bridge #(
  parameter int RX_TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst_n_sync,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        apbm_psel,
  output logic        apbm_penable,
  output logic        apbm_pwrite,
  output logic [15:0] apbm_paddr,
  output logic [31:0] apbm_pwdata,
  input  logic [31:0] apbm_prdata,
  input  logic        apbm_pready,
  input  logic        apbm_pslverr,
  output logic        busy
);

  localparam int TW = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_CMD,
    S_ADDR,
    S_WDATA,
    S_SETUP,
    S_ACCESS,
    S_RDATA,
    S_STATUS
  } state_t;

  state_t r_state;
  state_t w_next;

  logic          r_live;
  logic [1:0]    r_cnt;
  logic [TW-1:0] r_to;
  logic          r_wr;
  logic [15:0]   r_addr;
  logic [31:0]   r_wdat;
  logic [31:0]   r_rdat;
  logic [7:0]    r_stat;
  logic [15:0]   r_paddr;
  logic [31:0]   r_pwdata;
  logic          r_pwrite;

  logic          w_rx_en;
  logic          w_rx_acc;
  logic          w_tx_acc;
  logic          w_to_hit;
  logic          w_cmd_ok;
  logic [15:0]   w_addr_sh;
  logic [31:0]   w_wdat_sh;

  // rx_ready stays low for the first cycle out of reset (r_live).
  assign w_rx_en  = r_live &&
                    (r_state inside {S_CMD, S_ADDR, S_WDATA});
  assign rx_ready = w_rx_en;
  assign w_rx_acc = rx_valid && w_rx_en;

  assign tx_valid = r_state inside {S_RDATA, S_STATUS};
  assign w_tx_acc = tx_valid && tx_ready;

  assign w_cmd_ok  = (rx_data == 8'h00) || (rx_data == 8'h01);
  assign w_addr_sh = {rx_data, r_addr[15:8]};
  assign w_wdat_sh = {rx_data, r_wdat[31:8]};

  // Idle-gap watchdog for partially received frames; 0 disables it.
  assign w_to_hit = (RX_TIMEOUT != 0) && !w_rx_acc &&
                    (r_to == TW'(RX_TIMEOUT));

  assign apbm_psel    = r_state inside {S_SETUP, S_ACCESS};
  assign apbm_penable = r_state == S_ACCESS;
  assign apbm_pwrite  = r_pwrite;
  assign apbm_paddr   = r_paddr;
  assign apbm_pwdata  = r_pwdata;
  assign busy         = r_state != S_CMD;

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      r_state <= S_CMD;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    tx_data = 8'h00;
    unique case (r_state)
      S_CMD: begin
        if (w_rx_acc) begin
          w_next = w_cmd_ok ? S_ADDR : S_STATUS;
        end
      end
      S_ADDR: begin
        if (w_rx_acc && r_cnt == 2'd1) begin
          w_next = r_wr ? S_WDATA : S_SETUP;
        end else if (w_to_hit) begin
          w_next = S_CMD;
        end
      end
      S_WDATA: begin
        if (w_rx_acc && r_cnt == 2'd3) begin
          w_next = S_SETUP;
        end else if (w_to_hit) begin
          w_next = S_CMD;
        end
      end
      S_SETUP: begin
        w_next = S_ACCESS;
      end
      S_ACCESS: begin
        if (apbm_pready) begin
          w_next = r_wr ? S_STATUS : S_RDATA;
        end
      end
      S_RDATA: begin
        tx_data = r_rdat[8*r_cnt +: 8];
        if (w_tx_acc && r_cnt == 2'd3) begin
          w_next = S_STATUS;
        end
      end
      S_STATUS: begin
        tx_data = r_stat;
        if (w_tx_acc) begin
          w_next = S_CMD;
        end
      end
      default: begin
        w_next = S_CMD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      r_live <= 1'b0;
      r_cnt  <= 2'd0;
      r_to   <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_next != r_state) begin
        r_cnt <= 2'd0;
      end else if (w_rx_acc || w_tx_acc) begin
        r_cnt <= r_cnt + 2'd1;
      end
      if ((r_state inside {S_ADDR, S_WDATA}) && !w_rx_acc) begin
        r_to <= r_to + 1'b1;
      end else begin
        r_to <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      r_wr   <= 1'b0;
      r_addr <= 16'h0000;
      r_wdat <= 32'h0;
      r_rdat <= 32'h0;
      r_stat <= 8'h00;
    end else begin
      if (r_state == S_CMD && w_rx_acc) begin
        r_wr   <= rx_data[0];
        r_stat <= 8'h02;
      end
      if (r_state == S_ADDR && w_rx_acc) begin
        r_addr <= w_addr_sh;
      end
      if (r_state == S_WDATA && w_rx_acc) begin
        r_wdat <= w_wdat_sh;
      end
      if (r_state == S_ACCESS && apbm_pready) begin
        r_rdat <= apbm_prdata;
        r_stat <= {7'b0, apbm_pslverr};
      end
    end
  end

  // APB request fields load on SETUP entry so they hold through ACCESS
  // and keep their last value between transfers.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      r_paddr  <= 16'h0000;
      r_pwdata <= 32'h0;
      r_pwrite <= 1'b0;
    end else begin
      if (r_state == S_ADDR && w_next == S_SETUP) begin
        r_paddr  <= w_addr_sh;
        r_pwrite <= 1'b0;
      end
      if (r_state == S_WDATA && w_next == S_SETUP) begin
        r_paddr  <= r_addr;
        r_pwdata <= w_wdat_sh;
        r_pwrite <= 1'b1;
      end
    end
  end

endmodule
